// File: rtl/tetris_input_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tetris_pkg
//   Shared definitions for the Tetris switch input controller.
//   - Command encodings sent to the game core on cmd_code.
//   - REPEAT_MASK: which commands may auto-repeat while their switch is held.
//   - rep_state_t: states of the per-command auto-repeat FSM.
//   - lowest_idx(): fixed-priority pick used by the output arbiter.
// ---------------------------------------------------------------------------
package tetris_pkg;

  localparam int NUM_CMDS = 6;

  localparam logic [2:0] CMD_LEFT      = 3'd0;
  localparam logic [2:0] CMD_RIGHT     = 3'd1;
  localparam logic [2:0] CMD_ROTATE    = 3'd2;
  localparam logic [2:0] CMD_SOFT_DROP = 3'd3;
  localparam logic [2:0] CMD_HARD_DROP = 3'd4;
  localparam logic [2:0] CMD_PAUSE     = 3'd5;

  // Only movement commands (LEFT, RIGHT, SOFT_DROP) auto-repeat.
  localparam logic [NUM_CMDS-1:0] REPEAT_MASK = 6'b001011;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rep_state_t;

  // Index of the lowest set bit; 0 when the mask is empty (caller checks for empty).
  function automatic logic [2:0] lowest_idx(input logic [NUM_CMDS-1:0] m);
    lowest_idx = 3'd0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// tetris_input_ctrl_if
//   Command channel from the input controller to the game core.
//   Signals: cmd_valid, cmd_ready, cmd_code[2:0].
//   Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both 1. While cmd_valid=1 and cmd_ready=0 the producer holds
//   cmd_valid and cmd_code unchanged. cmd_ready may be driven independently of
//   cmd_valid; cmd_code is only meaningful while cmd_valid=1.
//   Modports: master (controller side), slave (game core side).
// ---------------------------------------------------------------------------
interface tetris_input_ctrl_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);

endinterface

// File: rtl/tetris_input_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//   One switch bit: 2-flop synchroniser followed by a debouncer. The level
//   output only changes after the synchronised input has disagreed with it
//   for DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
//   Ports: clk, reset (sync, active-low), sw (raw async bit), level (debounced).
// ---------------------------------------------------------------------------
module sw_debounce #(
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W      = 22
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// ---------------------------------------------------------------------------
// tetris_input_ctrl
//   Turns eight raw board switches into game commands. Each switch is
//   synchronised and debounced; rising edges of sw_clean[5:0] (plus optional
//   auto-repeat ticks) set bits in a pending mask, and the lowest pending
//   command is handed to the game core over a valid/ready channel.
//   Ports:
//     clk, reset      clock, synchronous active-low reset
//     sw[7:0]         raw switches
//     sw_clean[7:0]   debounced switch levels
//     cmd             command channel (tetris_input_ctrl_if.master)
//     pend[5:0]       pending command mask (debug view)
//     rep_state       per-command auto-repeat FSM state (debug view, 0 if unused)
//   Build option: define INPUT_AUTOREPEAT_EN to enable auto-repeat of
//   LEFT/RIGHT/SOFT_DROP while the switch is held.
// ---------------------------------------------------------------------------
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int DEB_CYCLES   = 250000,
  parameter int REPEAT_DELAY = 3000000,
  parameter int REPEAT_RATE  = 1000000,
  parameter int CNT_W        = 22
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   sw,
  output logic [7:0]                   sw_clean,
  tetris_input_ctrl_if.master          cmd,
  output logic [NUM_CMDS-1:0]          pend,
  output logic [NUM_CMDS-1:0][1:0]     rep_state
);

  // Every timing parameter must fit in the shared counter width.
  if (CNT_W < 2 || CNT_W > 30 || DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      (DEB_CYCLES - 1) >= (1 << CNT_W) || (REPEAT_DELAY - 1) >= (1 << CNT_W) ||
      (REPEAT_RATE - 1) >= (1 << CNT_W)) begin : g_bad_cfg
    $error("tetris_input_ctrl: CNT_W too small for the timing parameters");
  end

  // ---- sync + debounce, one instance per switch --------------------------
  for (genvar i = 0; i < 8; i++) begin : g_deb
    sw_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .sw    (sw[i]),
      .level (sw_clean[i])
    );
  end

  // ---- rising-edge detect (releases never produce commands) ---------------
  logic [NUM_CMDS-1:0] clean_d;
  logic [NUM_CMDS-1:0] press;
  logic [NUM_CMDS-1:0] tick;

  always_ff @(posedge clk) begin
    if (!reset) clean_d <= '0;
    else        clean_d <= sw_clean[NUM_CMDS-1:0];
  end

  assign press = sw_clean[NUM_CMDS-1:0] & ~clean_d;

  // ---- auto-repeat --------------------------------------------------------
`ifdef INPUT_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  for (genvar i = 0; i < NUM_CMDS; i++) begin : g_rep
    if (REPEAT_MASK[i]) begin : g_on
      rep_state_t       state, state_next;
      logic [CNT_W-1:0] cnt, cnt_next;
      logic             tick_r;

      always_ff @(posedge clk) begin
        if (!reset) begin
          state <= R_IDLE;
          cnt   <= '0;
        end else begin
          state <= state_next;
          cnt   <= cnt_next;
        end
      end

      always_comb begin
        state_next = state;
        cnt_next   = cnt;
        tick_r     = 1'b0;
        // Releasing the switch cancels repeating from any state.
        if (!sw_clean[i]) begin
          state_next = R_IDLE;
          cnt_next   = '0;
        end else begin
          case (state)
            R_IDLE: begin
              if (press[i]) begin
                state_next = R_DELAY;
                cnt_next   = '0;
              end
            end
            R_DELAY: begin
              if (cnt == DLY_LAST) begin
                tick_r     = 1'b1;
                state_next = R_REPEAT;
                cnt_next   = '0;
              end else begin
                cnt_next = cnt + 1'b1;
              end
            end
            R_REPEAT: begin
              if (cnt == RATE_LAST) begin
                tick_r   = 1'b1;
                cnt_next = '0;
              end else begin
                cnt_next = cnt + 1'b1;
              end
            end
            default: begin
              state_next = R_IDLE;
              cnt_next   = '0;
            end
          endcase
        end
      end

      assign tick[i]      = tick_r;
      assign rep_state[i] = state;
    end else begin : g_off
      assign tick[i]      = 1'b0;
      assign rep_state[i] = R_IDLE;
    end
  end
`else
  assign tick      = '0;
  assign rep_state = '0;
`endif

  // ---- pending mask, arbiter, output register -----------------------------
  logic                load;
  logic [2:0]          pick;
  logic [NUM_CMDS-1:0] clr;
  logic [NUM_CMDS-1:0] pend_next;

  always_comb begin
    load = !cmd.cmd_valid || cmd.cmd_ready;
    pick = lowest_idx(pend);
    clr  = '0;
    if (load && (pend != '0)) clr = NUM_CMDS'(1) << pick;
    // A new press/tick on the bit being cleared keeps it pending.
    pend_next = (pend & ~clr) | press | tick;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend          <= '0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_code  <= 3'd0;
    end else begin
      pend <= pend_next;
      if (load) begin
        if (pend != '0) begin
          cmd.cmd_valid <= 1'b1;
          cmd.cmd_code  <= pick;
        end else begin
          cmd.cmd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
`timescale 1ns/1ps
module tb_tetris_input_ctrl;
  import tetris_pkg::*;

  localparam int DEB   = 4;
  localparam int RDLY  = 8;
  localparam int RRATE = 3;

  // ---- clock / reset / DUT ----------------------------------------------
  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [7:0]               sw = 8'h00;
  logic [7:0]               sw_clean;
  logic [NUM_CMDS-1:0]      pend;
  logic [NUM_CMDS-1:0][1:0] rep_state;

  tetris_input_ctrl_if cmd_if ();

  tetris_input_ctrl #(
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RDLY),
    .REPEAT_RATE  (RRATE),
    .CNT_W        (22)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .sw_clean  (sw_clean),
    .cmd       (cmd_if),
    .pend      (pend),
    .rep_state (rep_state)
  );

  always #5 clk = ~clk;

  // ---- bookkeeping --------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---- behavioural model --------------------------------------------------
  // Debounced level flips once the last DEB synchronised samples all disagree
  // with it; commands are queued as a set and handed out lowest index first.
  logic [7:0]          m_s1, m_s2, m_clean;
  logic [NUM_CMDS-1:0] m_prev, m_pend;
  logic                m_valid;
  logic [2:0]          m_code;
  logic [7:0]          hist[$];
  int                  hold[NUM_CMDS];
  bit                  active[NUM_CMDS];
  bit                  live = 1'b0;

  always @(posedge clk) begin
    logic [NUM_CMDS-1:0] prs, tk, clr;
    bit  found, all_diff;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_prev = '0; m_pend = '0;
      m_valid = 1'b0; m_code = '0;
      hist.delete();
      for (int b = 0; b < NUM_CMDS; b++) begin hold[b] = 0; active[b] = 1'b0; end
      live = 1'b1;
    end else begin
      prs = m_clean[NUM_CMDS-1:0] & ~m_prev;
      tk  = '0;
`ifdef INPUT_AUTOREPEAT_EN
      for (int b = 0; b < NUM_CMDS; b++) begin
        if (b == 0 || b == 1 || b == 3) begin
          if (prs[b]) begin
            active[b] = 1'b1;
            hold[b]   = 0;
          end else if (active[b] && m_clean[b]) begin
            hold[b]++;
            if (hold[b] == RDLY || (hold[b] > RDLY && (hold[b] - RDLY) % RRATE == 0)) tk[b] = 1'b1;
          end else begin
            active[b] = 1'b0;
          end
        end
      end
`endif
      clr = '0;
      if (!m_valid || cmd_if.cmd_ready) begin
        found = 1'b0;
        for (int b = 0; b < NUM_CMDS; b++) begin
          if (!found && m_pend[b]) begin
            found   = 1'b1;
            m_code  = 3'(b);
            clr[b]  = 1'b1;
          end
        end
        m_valid = found;
      end
      m_pend = (m_pend & ~clr) | prs | tk;
      m_prev = m_clean[NUM_CMDS-1:0];
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        for (int b = 0; b < 8; b++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][b] == m_clean[b]) all_diff = 1'b0;
          if (all_diff) m_clean[b] = ~m_clean[b];
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  // ---- per-cycle compare against the model -------------------------------
  always @(negedge clk) begin
    if (live) begin
      check("model_sw_clean", 32'(sw_clean), 32'(m_clean));
      check("model_cmd_valid", 32'(cmd_if.cmd_valid), 32'(m_valid));
      check("model_pend", 32'(pend), 32'(m_pend));
      if (m_valid) check("model_cmd_code", 32'(cmd_if.cmd_code), 32'(m_code));
    end
  end

  // ---- scoreboard: accepted commands vs hand-written expected list --------
  always @(negedge clk) begin
    logic [2:0] e;
    if (live && reset && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd actual=%0d required=none t=%0t", cmd_if.cmd_code, $time);
      end else begin
        e = exp_q.pop_front();
        check("accept_code", 32'(cmd_if.cmd_code), 32'(e));
      end
    end
  end

  // ---- driver tasks -------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d_left required=0_left", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---- watchdog -----------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---- directed stimulus --------------------------------------------------
  initial begin
    // Reset with every switch held.
    reset = 1'b0;
    sw = 8'hFF;
    cmd_if.cmd_ready = 1'b1;
    step(5);
    check("rst_sw_clean", 32'(sw_clean), 32'h0);
    check("rst_valid", 32'(cmd_if.cmd_valid), 32'h0);
    check("rst_code", 32'(cmd_if.cmd_code), 32'h0);
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_rep_state", 32'(rep_state), 32'h0);

    for (int k = 0; k < NUM_CMDS; k++) exp_q.push_back(3'(k));
    reset = 1'b1;
    step(5);
    check("rel_clean_e5", 32'(sw_clean), 32'h00);
    step(1);
    check("rel_clean_e6", 32'(sw_clean), 32'hFF);
    step(1);
    check("rel_valid_e7", 32'(cmd_if.cmd_valid), 32'h0);
    check("rel_pend_e7", 32'(pend), 32'h3F);
    for (int k = 0; k < NUM_CMDS; k++) begin
      step(1);
      check("rel_burst_valid", 32'(cmd_if.cmd_valid), 32'h1);
      check("rel_burst_code", 32'(cmd_if.cmd_code), 32'(k));
    end
    step(1);
    check("rel_burst_end", 32'(cmd_if.cmd_valid), 32'h0);
    drain("reset_burst", 5);
    sw = 8'h00;
    step(12);

    // Glitch shorter than the debounce window.
    sw = 8'h04;
    step(3);
    sw = 8'h00;
    step(12);
    check("glitch_clean", 32'(sw_clean), 32'h0);
    check("glitch_pend", 32'(pend), 32'h0);
    check("glitch_valid", 32'(cmd_if.cmd_valid), 32'h0);

    // Long press of ROTATE.
    exp_q.push_back(CMD_ROTATE);
    sw = 8'h04;
    step(10);
    check("rot_clean", 32'(sw_clean), 32'h04);
    sw = 8'h00;
    drain("rotate", 20);
    step(12);

    // Backpressure: LEFT and HARD_DROP together.
    cmd_if.cmd_ready = 1'b0;
    sw = 8'h11;
    step(10);
    check("bp_valid", 32'(cmd_if.cmd_valid), 32'h1);
    check("bp_code", 32'(cmd_if.cmd_code), 32'(CMD_LEFT));
    check("bp_pend", 32'(pend), 32'h10);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("bp_hold_valid", 32'(cmd_if.cmd_valid), 32'h1);
      check("bp_hold_code", 32'(cmd_if.cmd_code), 32'(CMD_LEFT));
    end
    exp_q.push_back(CMD_LEFT);
    exp_q.push_back(CMD_HARD_DROP);
    cmd_if.cmd_ready = 1'b1;
    drain("backpressure", 10);
    sw = 8'h00;
    step(12);

    // Merge: RIGHT pressed twice while still pending behind PAUSE.
    cmd_if.cmd_ready = 1'b0;
    sw = 8'h20;
    step(10);
    check("merge_pause_code", 32'(cmd_if.cmd_code), 32'(CMD_PAUSE));
    sw = 8'h22;
    step(10);
    check("merge_pend1", 32'(pend), 32'h02);
    sw = 8'h20;
    step(10);
    check("merge_release", 32'(sw_clean), 32'h20);
    sw = 8'h22;
    step(10);
    check("merge_pend2", 32'(pend), 32'h02);
    exp_q.push_back(CMD_PAUSE);
    exp_q.push_back(CMD_RIGHT);
    cmd_if.cmd_ready = 1'b1;
    drain("merge", 10);
    step(5);
    check("merge_idle", 32'(cmd_if.cmd_valid), 32'h0);
    sw = 8'h00;
    step(12);

    // Hold LEFT: press plus repeat ticks at +8, +11, ... +32 when enabled.
`ifdef INPUT_AUTOREPEAT_EN
    for (int k = 0; k < 10; k++) exp_q.push_back(CMD_LEFT);
`else
    exp_q.push_back(CMD_LEFT);
`endif
    sw = 8'h01;
    step(35);
    sw = 8'h00;
    drain("hold_left", 20);
    step(12);

    // Reset while a command is presented and another is pending.
    cmd_if.cmd_ready = 1'b0;
    sw = 8'h03;
    step(10);
    check("midrst_pre_valid", 32'(cmd_if.cmd_valid), 32'h1);
    check("midrst_pre_pend", 32'(pend), 32'h02);
    reset = 1'b0;
    sw = 8'h00;
    step(1);
    check("midrst_valid", 32'(cmd_if.cmd_valid), 32'h0);
    check("midrst_pend", 32'(pend), 32'h0);
    check("midrst_clean", 32'(sw_clean), 32'h0);
    step(2);
    reset = 1'b1;
    cmd_if.cmd_ready = 1'b1;
    step(20);
    check("midrst_after_valid", 32'(cmd_if.cmd_valid), 32'h0);
    check("midrst_after_pend", 32'(pend), 32'h0);
    check("midrst_after_q", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
